// File: rtl/uart_pkg.sv
// Shared definitions for the UART parity engine.
//   par_mode_e : parity mode encoding (none / even / odd / mark)
//   state_e    : engine FSM state encoding (IDLE / ACCUM / PAR)
//   par_bit()  : parity bit for a mode given the XOR of all data bits
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } par_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    PAR   = 2'b10
  } state_e;

  function automatic logic par_bit(input par_mode_e m, input logic acc);
    logic p;
    case (m)
      PAR_EVEN: p = acc;
      PAR_ODD:  p = ~acc;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_parity_engine.sv
// Serial parity generator/checker for the UART TX/RX datapaths.
// Accumulates DATA_W data bits (one per bit_valid, LSB first), produces the
// parity bit for the mode latched at start, and compares it against par_in.
//   clk, reset_n            : clock (rising edge), async active-low reset
//   mode, start             : parity mode (sampled on start), frame start
//   bit_valid, bit_in       : data bit strobe and value
//   par_valid, par_in       : parity-bit strobe and received/looped-back bit
//   err_clr                 : synchronous clear of err_count
//   busy                    : frame in progress
//   parity_rdy, parity_out  : generated parity bit, valid while in PAR
//   done, parity_err        : 1-cycle completion pulse and mismatch flag
//   err_count               : saturating count of parity errors
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic                 start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 par_valid,
  input  logic                 par_in,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 parity_rdy,
  output logic                 parity_out,
  output logic                 done,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_e         state_q;
  par_mode_e      mode_q;
  logic           acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic acc_d;
  logic err_hit;

  assign acc_d = acc_q ^ bit_in;
  assign busy  = (state_q != IDLE);

  // A start in the same cycle as par_valid discards the frame, so it
  // must not count as an error either.
  assign err_hit = (state_q == PAR) && par_valid && !start && (par_in != parity_out);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mode_q     <= PAR_NONE;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      parity_rdy <= 1'b0;
      parity_out <= 1'b0;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      done       <= 1'b0;
      parity_err <= 1'b0;
      if (start) begin
        // Restart from any state; a bit strobed alongside start is bit 0.
        state_q    <= ACCUM;
        mode_q     <= par_mode_e'(mode);
        parity_rdy <= 1'b0;
        parity_out <= 1'b0;
        acc_q      <= bit_valid & bit_in;
        cnt_q      <= bit_valid ? CNT_W'(1) : '0;
      end else begin
        case (state_q)
          ACCUM: begin
            if (bit_valid) begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == LAST_IDX) begin
                if (mode_q != PAR_NONE) begin
                  state_q    <= PAR;
                  parity_rdy <= 1'b1;
                  parity_out <= par_bit(mode_q, acc_d);
                end else begin
                  state_q <= IDLE;
                  done    <= 1'b1;
                end
              end
            end
          end
          PAR: begin
            if (par_valid) begin
              state_q    <= IDLE;
              parity_rdy <= 1'b0;
              done       <= 1'b1;
              parity_err <= (par_in != parity_out);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (err_hit && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_parity_engine.sv
module tb_uart_parity_engine;

  typedef struct {
    logic par;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic start8 = 1'b0, start7 = 1'b0;
  logic bit_valid = 1'b0, bit_in = 1'b0;
  logic par_valid = 1'b0, par_in = 1'b0;
  logic err_clr = 1'b0;
  logic sel7 = 1'b0;

  logic b8, r8, p8, d8, e8;
  logic b7, r7, p7, d7, e7;
  logic [7:0] c8, c7;

  logic busy, rdy, pout, done, perr;
  logic [7:0] ecnt;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_parity_engine #(.DATA_W(8), .ERR_CNT_W(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .start(start8),
    .bit_valid(bit_valid), .bit_in(bit_in), .par_valid(par_valid), .par_in(par_in),
    .err_clr(err_clr), .busy(b8), .parity_rdy(r8), .parity_out(p8), .done(d8),
    .parity_err(e8), .err_count(c8)
  );

  uart_parity_engine #(.DATA_W(7), .ERR_CNT_W(8)) u_dut7 (
    .clk(clk), .reset_n(reset_n), .mode(mode), .start(start7),
    .bit_valid(bit_valid), .bit_in(bit_in), .par_valid(par_valid), .par_in(par_in),
    .err_clr(err_clr), .busy(b7), .parity_rdy(r7), .parity_out(p7), .done(d7),
    .parity_err(e7), .err_count(c7)
  );

  assign busy = sel7 ? b7 : b8;
  assign rdy  = sel7 ? r7 : r8;
  assign pout = sel7 ? p7 : p8;
  assign done = sel7 ? d7 : d8;
  assign perr = sel7 ? e7 : e8;
  assign ecnt = sel7 ? c7 : c8;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {26'd0, busy, rdy, pout, done, perr, |ecnt}, 32'd0);
  endtask

  task automatic set_start(input logic v);
    if (sel7) start7 = v; else start8 = v;
  endtask

  // Drives one frame; the expected parity/error go into the scoreboard at launch
  // and are popped when done is seen.
  task automatic run_frame(input logic [1:0] m, input logic [8:0] data, input int nb,
                           input int gap, input logic pin, input logic clr,
                           input logic bit_with_start);
    exp_t e;
    exp_t got;
    logic x;
    int first;
    x = 1'b0;
    for (int i = 0; i < nb; i++) x ^= data[i];
    case (m)
      2'b01:   e.par = x;
      2'b10:   e.par = ~x;
      2'b11:   e.par = 1'b1;
      default: e.par = 1'b0;
    endcase
    e.err = (m != 2'b00) && (pin != e.par);
    sb.push_back(e);

    mode = m;
    set_start(1'b1);
    bit_valid = bit_with_start;
    bit_in = bit_with_start ? data[0] : 1'b0;
    tick();
    set_start(1'b0);
    bit_valid = 1'b0;
    first = bit_with_start ? 1 : 0;
    for (int i = first; i < nb; i++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_rdy", rdy, 1'b0);
      end
      bit_valid = 1'b1;
      bit_in = data[i];
      tick();
      bit_valid = 1'b0;
      if (i < nb - 1) begin
        chk("accum_rdy", rdy, 1'b0);
        chk("accum_done", done, 1'b0);
        chk("accum_busy", busy, 1'b1);
      end
    end
    if (m != 2'b00) begin
      chk("par_rdy", rdy, 1'b1);
      chk("par_out", pout, sb[0].par);
      chk("par_done_low", done, 1'b0);
      tick();
      chk("par_hold_rdy", rdy, 1'b1);
      chk("par_hold_out", pout, sb[0].par);
      par_valid = 1'b1;
      par_in = pin;
      err_clr = clr;
      tick();
      par_valid = 1'b0;
      err_clr = 1'b0;
    end
    got.par = 1'b0;
    got.err = perr;
    chk("done", done, 1'b1);
    e = sb.pop_front();
    chk("parity_err", got.err, e.err);
    chk("rdy_after", rdy, 1'b0);
    chk("busy_after", busy, 1'b0);
    tick();
    chk("done_pulse", done, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_all_zero("reset8");
    sel7 = 1'b1;
    chk_all_zero("reset7");
    sel7 = 1'b0;
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Even parity, 5 ones -> 1, matching par_in
    run_frame(2'b01, 9'b000110111, 8, 0, 1'b1, 1'b0, 1'b0);
    chk("cnt_t1", ecnt, 8'd0);

    // Odd parity, 4 ones -> 1, par_in=0 mismatch
    run_frame(2'b10, 9'b000001111, 8, 0, 1'b0, 1'b0, 1'b0);
    chk("cnt_t2", ecnt, 8'd1);

    // No parity: done right after the 8th bit, parity_rdy never set
    run_frame(2'b00, 9'b010111101, 8, 0, 1'b0, 1'b0, 1'b0);
    chk("cnt_t3", ecnt, 8'd1);

    // par_valid outside PAR must not do anything
    par_valid = 1'b1; par_in = 1'b1;
    tick();
    par_valid = 1'b0;
    chk("idle_parvalid_done", done, 1'b0);
    chk("idle_parvalid_cnt", ecnt, 8'd1);

    // Abort after 4 bits, restart with a bit on the start cycle
    mode = 2'b01;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in = i[0];
      tick();
      chk("abort_done", done, 1'b0);
    end
    bit_valid = 1'b0;
    run_frame(2'b01, 9'b010101001, 8, 0, 1'b0, 1'b0, 1'b1);
    chk("cnt_t4", ecnt, 8'd1);

    // DATA_W=7, mark parity with gaps between strobes
    sel7 = 1'b1;
    run_frame(2'b11, 9'b001011001, 7, 2, 1'b1, 1'b0, 1'b0);
    chk("cnt7_0", ecnt, 8'd0);
    run_frame(2'b11, 9'b000000000, 7, 0, 1'b0, 1'b0, 1'b0);
    chk("cnt7_1", ecnt, 8'd1);
    for (int k = 0; k < 299; k++) begin
      run_frame(2'b11, 9'($urandom_range(0, 127)), 7, 0, 1'b0, 1'b0, 1'b0);
    end
    chk("cnt7_sat", ecnt, 8'd255);
    // err_clr beats the simultaneous mismatch increment
    run_frame(2'b11, 9'b001111111, 7, 1, 1'b0, 1'b1, 1'b0);
    chk("cnt7_clr", ecnt, 8'd0);
    sel7 = 1'b0;

    // Reset mid-ACCUM
    mode = 2'b01;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    tick();
    chk("pre_rst_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst_accum");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_done", done, 1'b0);
    end
    bit_valid = 1'b0;

    // Reset while in PAR with a non-zero error count
    run_frame(2'b01, 9'b000000001, 8, 0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_cnt", ecnt, 8'd1);
    mode = 2'b10;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    chk("pre_rst_rdy", rdy, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst_par");
    tick();
    reset_n = 1'b1;
    par_valid = 1'b1; par_in = 1'b1;
    tick();
    par_valid = 1'b0;
    chk_all_zero("post_rst_par");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
